word_access_seq: RTL and testbench

Byte-addressed 32-bit access sequencer sitting between the data-entry/display logic and a single byte-wide synchronous RAM. It accepts one word read or write request, performs four sequential byte accesses at addr, addr+1, addr+2, addr+3 with address wrap-around, and assembles or splits the word big-endian. It returns a one-cycle `done` pulse. The read word feeds the 7-segment display path; the write word comes from the nibble-entry register.

---
 rtl/word_access_seq.sv | 160 ++++++++++++++++
 tb/tb_word_access_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/word_access_seq.sv
// Word-to-byte access sequencer: runs four big-endian byte accesses to a byte-wide
// registered-address RAM for one 32-bit read or write, then pulses done.
module word_access_seq #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, TAIL = 2'd2, DONE = 2'd3} state_t;

  state_t            state_r, state_s;
  logic [1:0]        idx_r, idx_s;
  logic [ADDR_W-1:0] base_r, base_s;
  logic              we_r, we_s;
  logic [31:0]       wd_r, wd_s;
  logic [31:0]       shadow_r, shadow_s;
  logic [31:0]       rdata_r, rdata_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic              mem_we_r, mem_we_s;
  logic [7:0]        mem_wdata_r, mem_wdata_s;

  // Byte index 0 is the most significant byte of the word.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (i)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  // Next-state and request capture.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    base_s  = base_r;
    we_s    = we_r;
    wd_s    = wd_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_s = ACCESS;
          idx_s   = 2'd0;
          base_s  = addr;
          we_s    = we;
          wd_s    = wdata;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        idx_s = idx_r + 2'd1;
        if (idx_r == 2'd3) begin
          state_s = TAIL;
        end else begin
          state_s = ACCESS;
        end
      end
      TAIL:    state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Read data arrives one cycle after its address, so byte k lands while idx=k+1
  // (or in TAIL for the last byte); the last byte bypasses into rdata directly.
  always_comb begin
    shadow_s = shadow_r;
    rdata_s  = rdata_r;
    if (!we_r && (state_r == ACCESS) && (idx_r != 2'd0)) begin
      shadow_s = put_byte(shadow_r, idx_r - 2'd1, mem_rdata);
    end else if (!we_r && (state_r == TAIL)) begin
      shadow_s = put_byte(shadow_r, 2'd3, mem_rdata);
      rdata_s  = {shadow_r[31:8], mem_rdata};
    end else begin
      shadow_s = shadow_r;
    end
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
    if (state_s == ACCESS) begin
      mem_addr_s  = base_s + {{(ADDR_W-2){1'b0}}, idx_s};
      mem_we_s    = we_s;
      mem_wdata_s = we_s ? get_byte(wd_s, idx_s) : 8'h00;
    end else begin
      mem_addr_s  = base_s;
      mem_we_s    = 1'b0;
      mem_wdata_s = 8'h00;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= 2'd0;
      base_r      <= {ADDR_W{1'b0}};
      we_r        <= 1'b0;
      wd_r        <= 32'h0000_0000;
      shadow_r    <= 32'h0000_0000;
      rdata_r     <= 32'h0000_0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 8'h00;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      base_r      <= base_s;
      we_r        <= we_s;
      wd_r        <= wd_s;
      shadow_r    <= shadow_s;
      rdata_r     <= rdata_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      mem_addr_r  <= mem_addr_s;
      mem_we_r    <= mem_we_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign rdata     = rdata_r;
  assign mem_addr  = mem_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_word_access_seq.sv
// Directed self-checking bench for word_access_seq with a byte-wide
// registered-address RAM model preloaded with ram[i] = i.
module tb_word_access_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [256];
  logic        ram_init = 1'b0;
  int          check_cnt = 0;
  int          error_cnt = 0;
  int          done_cnt = 0;
  int          we_cnt = 0;
  int          hit40_cnt = 0;

  word_access_seq #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model plus event counters sampled at the active edge
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= i[7:0];
      ram_init <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
    if (done) done_cnt++;
    if (mem_we) we_cnt++;
    if (mem_we && mem_addr == 8'h40) hit40_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full request; checks every cycle E0..E6 against the fixed latency.
  task automatic run_op(input logic op_we, input logic [7:0] op_addr,
                        input logic [31:0] op_wdata, input logic [31:0] exp_rdata,
                        input logic poke);
    int          d0;
    logic [7:0]  ea;
    logic [31:0] sh;
    d0    = done_cnt;
    req   = 1'b1;
    we    = op_we;
    addr  = op_addr;
    wdata = op_wdata;
    step();
    req   = 1'b0;
    we    = ~op_we;
    addr  = 8'h55;
    wdata = 32'h0F0F_0F0F;
    for (int k = 0; k < 4; k++) begin
      ea = op_addr + 8'(k);
      sh = op_wdata >> (8 * (3 - k));
      check_val("mem_addr", {24'h0, mem_addr}, {24'h0, ea});
      check_val("mem_we", {31'h0, mem_we}, {31'h0, op_we});
      check_val("mem_wdata", {24'h0, mem_wdata}, op_we ? {24'h0, sh[7:0]} : 32'h0);
      check_val("busy_access", {31'h0, busy}, 32'h1);
      if (poke && k == 1) begin
        req  = 1'b1;
        we   = 1'b1;
        addr = 8'h40;
      end
      if (poke && k == 2) req = 1'b0;
      step();
    end
    check_val("tail_we", {31'h0, mem_we}, 32'h0);
    check_val("tail_done", {31'h0, done}, 32'h0);
    step();
    check_val("done_e5", {31'h0, done}, 32'h1);
    if (!op_we) check_val("rdata", rdata, exp_rdata);
    step();
    check_val("done_e6", {31'h0, done}, 32'h0);
    check_val("busy_e6", {31'h0, busy}, 32'h0);
    check_val("done_count", done_cnt - d0, 32'd1);
  endtask

  initial begin
    int   d0;
    int   w0;
    int   n;
    logic stable;
    rst_n = 1'b0;
    req   = 1'b1;
    we    = 1'b1;
    addr  = 8'h10;
    wdata = 32'h1234_5678;

    // reset held with req asserted
    w0 = we_cnt;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_busy", {31'h0, busy}, 32'h0);
      check_val("rst_done", {31'h0, done}, 32'h0);
      check_val("rst_rdata", rdata, 32'h0);
      check_val("rst_mem_we", {31'h0, mem_we}, 32'h0);
    end
    check_val("rst_no_writes", we_cnt - w0, 32'd0);
    rst_n = 1'b1;

    // aligned write then read
    run_op(1'b1, 8'h10, 32'h1234_5678, 32'h0, 1'b0);
    check_val("ram_10_13", {ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]}, 32'h1234_5678);
    run_op(1'b0, 8'h10, 32'h0, 32'h1234_5678, 1'b0);

    // wrap-around write, unaligned read
    run_op(1'b1, 8'hFE, 32'hAABB_CCDD, 32'h0, 1'b0);
    check_val("ram_wrap", {ram[8'hFE], ram[8'hFF], ram[8'h00], ram[8'h01]}, 32'hAABB_CCDD);
    run_op(1'b0, 8'hFF, 32'h0, 32'hBBCC_DD02, 1'b0);

    // request while busy
    run_op(1'b1, 8'h30, 32'hCAFE_F00D, 32'h0, 1'b1);
    check_val("no_hit_40", hit40_cnt, 32'd0);
    check_val("ram_30_33", {ram[8'h30], ram[8'h31], ram[8'h32], ram[8'h33]}, 32'hCAFE_F00D);
    check_val("rdata_after_write", rdata, 32'hBBCC_DD02);

    // reset mid-write at E2
    d0    = done_cnt;
    req   = 1'b1;
    we    = 1'b1;
    addr  = 8'h20;
    wdata = 32'h1122_3344;
    step();
    req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check_val("abort_busy", {31'h0, busy}, 32'h0);
    check_val("abort_rdata", rdata, 32'h0);
    check_val("abort_mem_we", {31'h0, mem_we}, 32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check_val("abort_no_done", done_cnt - d0, 32'd0);
    check_val("abort_ram", {ram[8'h20], ram[8'h21], ram[8'h22], ram[8'h23]}, 32'h1122_2223);

    // back-to-back reads with req held high
    req  = 1'b1;
    we   = 1'b0;
    addr = 8'h10;
    n    = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check_val("b2b_first_done", {31'h0, done}, 32'h1);
    check_val("b2b_first_lat", n, 32'd6);
    check_val("b2b_rdata", rdata, 32'h1234_5678);
    n      = 0;
    stable = 1'b1;
    do begin
      step();
      n++;
      if (!done && rdata !== 32'h1234_5678) stable = 1'b0;
    end while (!done && n < 20);
    check_val("b2b_period", n, 32'd7);
    check_val("b2b_rdata_hold", {31'h0, stable}, 32'h1);
    req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_val("final_idle", {31'h0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
